// File: rtl/usb_pkg.sv
// Shared types for the USB host transaction path: packet kinds sent to the
// encoder and the transaction sequencer states.
package usb_pkg;

    typedef enum logic [1:0] {
        TX_TOKEN = 2'b00,
        TX_DATA0 = 2'b01,
        TX_ACK   = 2'b10
    } tx_kind_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_TOKEN,
        ST_SEND_DATA,
        ST_WAIT_RESP,
        ST_WAIT_DATA,
        ST_SEND_ACK,
        ST_DONE
    } txn_state_t;

    function automatic logic is_send(input txn_state_t s);
        return (s == ST_SEND_TOKEN) || (s == ST_SEND_DATA) || (s == ST_SEND_ACK);
    endfunction

    function automatic tx_kind_t kind_of(input txn_state_t s);
        case (s)
            ST_SEND_DATA: return TX_DATA0;
            ST_SEND_ACK:  return TX_ACK;
            default:      return TX_TOKEN;
        endcase
    endfunction

endpackage

// File: rtl/usb_resp_timer.sv
// Response timer: cleared on entry to a receive state, counts while enabled,
// flags timeout after exactly TIMEOUT_CYC enabled cycles and then saturates.
module usb_resp_timer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign timeout = en && (r_count == LAST);

endmodule

// File: rtl/usb_txn_ctrl.sv
// Host-side USB transaction sequencer: issues token/data/handshake packets,
// waits for the device response with a timeout and retries failed attempts.
module usb_txn_ctrl
    import usb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int MAX_RETRY   = 8,
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          txn_start,
    input  logic          txn_is_in,
    output logic          tx_start,
    output logic [1:0]    tx_kind,
    input  logic          tx_done,
    output logic          host_sending,
    input  logic          ACK_rec,
    input  logic          NAK_rec,
    input  logic          DATA0_rec,
    input  logic          load_data,
    input  logic          crc_ok,
    output logic          txn_done,
    output logic          txn_ok,
    output logic [RW-1:0] retry_cnt
);

    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

    txn_state_t    r_state, w_state_next;
    logic          r_is_in, w_is_in_next;
    logic [RW-1:0] r_retry, w_retry_next;
    logic          r_ok, w_ok_next;
    logic          r_tx_start;
    tx_kind_t      r_tx_kind;
    logic          w_fail;
    logic          w_in_wait;
    logic          w_state_change;
    logic          w_enter_send;
    logic          w_timeout;

    assign w_in_wait      = (r_state == ST_WAIT_RESP) || (r_state == ST_WAIT_DATA);
    assign w_state_change = (w_state_next != r_state);
    assign w_enter_send   = w_state_change && is_send(w_state_next);

    usb_resp_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clr     (w_state_change),
        .en      (w_in_wait),
        .timeout (w_timeout)
    );

    always_comb begin
        w_state_next = r_state;
        w_is_in_next = r_is_in;
        w_retry_next = r_retry;
        w_ok_next    = r_ok;
        w_fail       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (txn_start) begin
                    w_is_in_next = txn_is_in;
                    w_retry_next = '0;
                    w_state_next = ST_SEND_TOKEN;
                end
            end
            ST_SEND_TOKEN: begin
                if (tx_done) w_state_next = r_is_in ? ST_WAIT_RESP : ST_SEND_DATA;
            end
            ST_SEND_DATA: begin
                if (tx_done) w_state_next = ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                // Response priority is ACK > DATA0 > NAK > timeout.
                if (ACK_rec) begin
                    if (r_is_in) begin
                        w_fail = 1'b1;
                    end else begin
                        w_state_next = ST_DONE;
                        w_ok_next    = 1'b1;
                    end
                end else if (DATA0_rec) begin
                    if (r_is_in) w_state_next = ST_WAIT_DATA;
                    else         w_fail       = 1'b1;
                end else if (NAK_rec || w_timeout) begin
                    w_fail = 1'b1;
                end
            end
            ST_WAIT_DATA: begin
                if (load_data) begin
                    if (crc_ok) w_state_next = ST_SEND_ACK;
                    else        w_fail       = 1'b1;
                end else if (w_timeout) begin
                    w_fail = 1'b1;
                end
            end
            ST_SEND_ACK: begin
                if (tx_done) begin
                    w_state_next = ST_DONE;
                    w_ok_next    = 1'b1;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase

        if (w_fail) begin
            if (r_retry == RETRY_LAST) begin
                w_state_next = ST_DONE;
                w_ok_next    = 1'b0;
            end else begin
                w_retry_next = r_retry + 1'b1;
                w_state_next = ST_SEND_TOKEN;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_is_in    <= 1'b0;
            r_retry    <= '0;
            r_ok       <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_kind  <= TX_TOKEN;
        end else begin
            r_state    <= w_state_next;
            r_is_in    <= w_is_in_next;
            r_retry    <= w_retry_next;
            r_ok       <= w_ok_next;
            r_tx_start <= w_enter_send;
            if (w_enter_send) r_tx_kind <= kind_of(w_state_next);
        end
    end

    assign tx_start     = r_tx_start;
    assign tx_kind      = r_tx_kind;
    assign host_sending = !w_in_wait;
    assign txn_done     = (r_state == ST_DONE);
    assign txn_ok       = (r_state == ST_DONE) && r_ok;
    assign retry_cnt    = r_retry;

endmodule
